// File: rtl/vec_ldst_seq.sv
// Vector load/store sequencer: moves one VLEN-element vector between data
// memory and one vector register through the register file's serial port.
module vec_ldst_seq #(
    parameter int VLEN = 16,
    parameter int AW   = 16,
    parameter int DW   = 16
) (
    input  logic                    Clk1,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic                    Op,
    input  logic [2:0]              VAddr,
    input  logic [AW-1:0]           Base,
    input  logic [AW-1:0]           Stride,
    output logic                    Busy,
    output logic                    Done,
    output logic [AW-1:0]           MemAddr,
    output logic                    MemRd,
    output logic                    MemWr,
    output logic [DW-1:0]           MemDataOut,
    input  logic [DW-1:0]           MemDataIn,
    output logic [2:0]              RegAddr,
    output logic [$clog2(VLEN)-1:0] RegIdx,
    output logic                    RegWR_s,
    output logic                    RegRD_s,
    output logic [DW-1:0]           RegDataOut,
    input  logic [DW-1:0]           RegDataIn
);

    localparam int IW = $clog2(VLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_n;
    logic [IW-1:0]   cnt_q, cnt_n;
    logic            drn_q, drn_n;
    logic            op_q, op_n;
    logic [2:0]      va_q, va_n;
    logic [AW-1:0]   stride_q, stride_n;
    logic [AW-1:0]   iaddr_q, iaddr_n;

    // Return stage: a read issued last cycle has its data on the bus now
    logic            p1v_q, p1v_n;
    logic [IW-1:0]   p1tag_q, p1tag_n;
    logic [AW-1:0]   p1addr_q, p1addr_n;

    logic            busy_n, done_n;
    logic            mrd_n, mwr_n, rrd_n, rwr_n;
    logic [AW-1:0]   maddr_n;
    logic [DW-1:0]   mdout_n, rdout_n;
    logic [2:0]      raddr_n;
    logic [IW-1:0]   ridx_n;

    logic            iss;
    logic            iss_op;
    logic [2:0]      iss_va;
    logic [AW-1:0]   iss_addr;
    logic [IW-1:0]   iss_idx;

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        drn_n    = drn_q;
        op_n     = op_q;
        va_n     = va_q;
        stride_n = stride_q;
        iaddr_n  = iaddr_q;
        p1v_n    = 1'b0;
        p1tag_n  = p1tag_q;
        p1addr_n = p1addr_q;
        busy_n   = Busy;
        done_n   = 1'b0;
        mrd_n    = 1'b0;
        mwr_n    = 1'b0;
        rrd_n    = 1'b0;
        rwr_n    = 1'b0;
        maddr_n  = MemAddr;
        mdout_n  = MemDataOut;
        raddr_n  = RegAddr;
        ridx_n   = RegIdx;
        rdout_n  = RegDataOut;
        iss      = 1'b0;
        iss_op   = op_q;
        iss_va   = va_q;
        iss_addr = iaddr_q;
        iss_idx  = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_n  = S_ISSUE;
                    op_n     = Op;
                    va_n     = VAddr;
                    stride_n = Stride;
                    iaddr_n  = Base;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    iss      = 1'b1;
                    iss_op   = Op;
                    iss_va   = VAddr;
                    iss_addr = Base;
                    iss_idx  = '0;
                end
            end
            S_ISSUE: begin
                p1v_n    = 1'b1;
                p1tag_n  = cnt_q;
                p1addr_n = iaddr_q;
                if (cnt_q == IW'(VLEN - 1)) begin
                    state_n = S_DRAIN;
                    drn_n   = 1'b0;
                end else begin
                    cnt_n    = cnt_q + IW'(1);
                    iaddr_n  = iaddr_q + stride_q;
                    iss      = 1'b1;
                    iss_addr = iaddr_q + stride_q;
                    iss_idx  = cnt_q + IW'(1);
                end
            end
            S_DRAIN: begin
                drn_n = 1'b1;
                if (drn_q) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase

        // Load reads memory and writes the register file; store is the mirror
        if (iss) begin
            if (iss_op) begin
                rrd_n   = 1'b1;
                raddr_n = iss_va;
                ridx_n  = iss_idx;
            end else begin
                mrd_n   = 1'b1;
                maddr_n = iss_addr;
            end
        end

        if (p1v_q) begin
            if (op_q) begin
                mwr_n   = 1'b1;
                maddr_n = p1addr_q;
                mdout_n = RegDataIn;
            end else begin
                rwr_n   = 1'b1;
                raddr_n = va_q;
                ridx_n  = p1tag_q;
                rdout_n = MemDataIn;
            end
        end
    end

    always_ff @(posedge Clk1 or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drn_q      <= 1'b0;
            op_q       <= 1'b0;
            va_q       <= '0;
            stride_q   <= '0;
            iaddr_q    <= '0;
            p1v_q      <= 1'b0;
            p1tag_q    <= '0;
            p1addr_q   <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            MemAddr    <= '0;
            MemRd      <= 1'b0;
            MemWr      <= 1'b0;
            MemDataOut <= '0;
            RegAddr    <= '0;
            RegIdx     <= '0;
            RegWR_s    <= 1'b0;
            RegRD_s    <= 1'b0;
            RegDataOut <= '0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            drn_q      <= drn_n;
            op_q       <= op_n;
            va_q       <= va_n;
            stride_q   <= stride_n;
            iaddr_q    <= iaddr_n;
            p1v_q      <= p1v_n;
            p1tag_q    <= p1tag_n;
            p1addr_q   <= p1addr_n;
            Busy       <= busy_n;
            Done       <= done_n;
            MemAddr    <= maddr_n;
            MemRd      <= mrd_n;
            MemWr      <= mwr_n;
            MemDataOut <= mdout_n;
            RegAddr    <= raddr_n;
            RegIdx     <= ridx_n;
            RegWR_s    <= rwr_n;
            RegRD_s    <= rrd_n;
            RegDataOut <= rdout_n;
        end
    end

endmodule

// File: doc/vec_ldst_seq.md
Name: vec_ldst_seq

Overview:
- Load/store sequencer that moves one 16-element vector between 16-bit data memory and one register of the 8x16x16 vector register file.
- Uses the register file's serial (per-element) port.
- Load: streams 16 memory words into the register file.
- Store: streams 16 register elements out to memory.
- Sits directly upstream (load) and downstream (store) of the vector register file, driven by the decode stage.

Parameters:
VLEN, 16, elements per vector (index counter width = log2(VLEN) = 4)
AW, 16, memory address width
DW, 16, element/memory data width

Ports:
Clk1  in  1  single clock; all state updates on posedge
Rst  in  1  asynchronous, active-high reset
Start  in  1  command strobe; sampled only in IDLE
Op  in  1  0 = load (mem->reg), 1 = store (reg->mem)
VAddr  in  3  vector register number
Base  in  AW  start memory address
Stride  in  AW  address increment between elements
Busy  out  1  high from accepted Start until Done
Done  out  1  one-cycle completion pulse
MemAddr  out  AW  memory address
MemRd  out  1  memory read strobe; data valid on MemDataIn one cycle later
MemWr  out  1  memory write strobe
MemDataOut  out  DW  store data to memory
MemDataIn  in  DW  load data from memory
RegAddr  out  3  vector register number to register file
RegIdx  out  4  element index to register file
RegWR_s  out  1  serial element write strobe
RegRD_s  out  1  serial element read strobe; data valid on RegDataIn one cycle later
RegDataOut  out  DW  element data to register file DataIn_s
RegDataIn  in  DW  element data from register file DataOut_s

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0, including Busy, Done, every strobe, addresses, RegIdx and data outputs; counters cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- Start handling:
  - Start with Busy=0 is accepted at a posedge.
  - On acceptance, latch Op, VAddr, Base and Stride; the next state is ISSUE.
  - Start while Busy=1 is ignored. No queueing.
- ISSUE lasts exactly VLEN cycles, with n = 0..15 in cycle n.
  - Load: MemRd=1, MemAddr=Base+n*Stride (modulo 2^AW).
  - Store: RegRD_s=1, RegAddr=VAddr, RegIdx=n.
- Stage 1, one cycle after issue n: the returned word (MemDataIn or RegDataIn) is registered with tag n.
- Stage 2, two cycles after issue n:
  - Load: RegWR_s=1, RegAddr=VAddr, RegIdx=n, RegDataOut=registered word.
  - Store: MemWr=1, MemAddr=Base+n*Stride, MemDataOut=registered word.
- Overlap is allowed. In load, MemRd (issue n) and RegWR_s (write n-2) assert in the same cycle. In store, RegRD_s and MemWr assert in the same cycle.
- DRAIN lasts 2 cycles, flushing writes for n=14 and n=15.
- DONE lasts 1 cycle with Done=1 and Busy still 1. It then returns to IDLE with Busy=0.
- Timing: if Start is accepted at edge 0, ISSUE spans cycles 1..16, write-backs occur in cycles 3..18, Done=1 in cycle 19, and Busy=1 in cycles 1..19.
- Exactly 16 write strobes occur per command. They are in ascending index order with no gaps.
- Stride=0 is legal and gives all elements the same address.
- Address arithmetic truncates to AW bits; wrap past 0xFFFF is silent.
- RegAddr, RegIdx and MemAddr hold their last value when their strobe is low. Strobes are never X after reset.
- Rst asserted mid-command: all strobes drop immediately (asynchronous) and no further reads or writes are issued. A partial vector write is left as-is and Done is not pulsed.
- The block never asserts RegWR_s and RegRD_s together, nor MemRd and MemWr together.

Test Plan:
1. Load: memory[0x0100+n]=0xA000+n, Start with Op=0, VAddr=2, Base=0x0100, Stride=1 -> RegWR_s in cycles 3..18 with RegIdx 0..15 and RegDataOut 0xA000..0xA00F; Done in cycle 19 only.
2. Store: register-file model returns 0x5500+idx, Start with Op=1, VAddr=5, Base=0x2000, Stride=2 -> MemWr 16 times at 0x2000, 0x2002, ..., 0x201E with data 0x5500..0x550F; Done in cycle 19.
3. Wrap: load with Base=0xFFFE, Stride=1 -> MemAddr sequence 0xFFFE, 0xFFFF, 0x0000, ..., 0x000D.
4. Busy ignore: Start pulsed again at cycle 8 with a different VAddr -> no effect, exactly 16 writes to the original VAddr, and one Done.
5. Reset mid-op: Rst asserted asynchronously at cycle 10 of a load -> all outputs 0 within the same cycle, no writes after it, Done never pulses; a new Start after reset runs a full 19-cycle command.
6. Back-to-back: Start held high continuously -> the second command is accepted at the edge after Done falls and Busy=0, giving a gap of one IDLE cycle between commands.
